// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption core.
// The cipher key is expanded once into an 11-entry round-key store.
// After that, one inverse round runs per clock, with round keys taken from 10 down to 0.
// The core uses a start/busy/done handshake. When a full schedule is already stored,
// a new block can reuse it.
module aes_inv_cipher_iter #(
    parameter bit KEY_REUSE = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         key_new,
    input  logic [127:0] din,
    input  logic [127:0] kin,
    output logic         busy,
    output logic         done,
    output logic [127:0] dout,
    output logic         key_valid
);

    typedef enum logic [2:0] {IDLE, KEXP, ADD0, ROUND, FINAL} state_t;

    state_t       state, state_nxt;
    logic [127:0] st;
    logic [3:0]   cnt;
    logic [3:0]   rnd;
    logic [127:0] key_mem [0:10];
    logic         expand;
    logic [127:0] iss_val;
    logic [127:0] key_next;

    // ---------------- GF(2^8) and S-box helpers ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; the inverse of zero comes out as zero.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int k);
        return (a << k) | (a >> (8 - k));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    // InvShiftRows followed by InvSubBytes. Byte k sits at row k%4 and column k/4.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[127-8*(4*c+row) -: 8] = inv_sbox(s[127-8*(4*((c-row+4)%4)+row) -: 8]);
        return r;
    endfunction

    function automatic logic [7:0] mc_coef(input int idx);
        case (idx)
            0:       return 8'h0e;
            1:       return 8'h0b;
            2:       return 8'h0d;
            default: return 8'h09;
        endcase
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   acc;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                acc = '0;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(s[127-8*(4*c+k) -: 8], mc_coef((k - row + 4) % 4));
                r[127-8*(4*c+row) -: 8] = acc;
            end
        return r;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One key-schedule word group: RotWord, SubWord, Rcon, then a chain of XORs.
    function automatic logic [127:0] key_step(input logic [127:0] prev, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(prev[23:16]), sbox(prev[15:8]), sbox(prev[7:0]), sbox(prev[31:24])}
             ^ {rc, 24'h0};
        w0 = prev[127:96] ^ t;
        w1 = prev[95:64]  ^ w0;
        w2 = prev[63:32]  ^ w1;
        w3 = prev[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    assign expand   = key_new || (KEY_REUSE == 1'b0) || !key_valid;
    assign iss_val  = inv_shift_sub(st);
    assign key_next = key_step(key_mem[cnt - 4'd1], rcon(cnt));

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = expand ? KEXP : ADD0;
            KEXP:    if (cnt == 4'd10) state_nxt = ADD0;
            ADD0:    state_nxt = ROUND;
            ROUND:   if (rnd == 4'd1) state_nxt = FINAL;
            FINAL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: busy covers every non-idle state.
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: block state, counters, result register and flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            st        <= '0;
            cnt       <= '0;
            rnd       <= '0;
            dout      <= '0;
            done      <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    st <= din;
                    if (expand) begin
                        key_valid <= 1'b0;
                        cnt       <= 4'd1;
                    end
                end
                KEXP: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd10) key_valid <= 1'b1;
                end
                ADD0: begin
                    st  <= st ^ key_mem[10];
                    rnd <= 4'd9;
                end
                ROUND: begin
                    st  <= inv_mix(iss_val ^ key_mem[rnd]);
                    rnd <= rnd - 4'd1;
                end
                FINAL: begin
                    dout <= iss_val ^ key_mem[0];
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Round-key store: key 0 is loaded on accept, and keys 1..10 come one per KEXP cycle.
    always_ff @(posedge clock) begin
        // NOTE: the key store has no reset; it holds data only, and key_valid says whether it can be used.
        if (!reset) begin
            if (state == IDLE && start && expand) key_mem[0] <= kin;
            else if (state == KEXP)               key_mem[cnt] <= key_next;
        end
    end

endmodule
